// File: rtl/requant_pkg.sv
// Shared types and constants for the requant parameter streamer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package requant_pkg;

    localparam int D_W     = 8;
    localparam int D_W_ACC = 32;

    // Largest meaningful right-shift for a D_W_ACC x D_W_ACC product
    localparam int MAX_E = 2 * D_W_ACC - 1;

    typedef logic signed [D_W_ACC-1:0] bias_t;
    typedef logic signed [D_W_ACC-1:0] mult_t;
    typedef logic signed [D_W-1:0]     shamt_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_t;

    // Saturate a shift amount into [0, MAX_E]
    function automatic shamt_t clamp_e(input shamt_t e);
        if (e < 0) begin
            return '0;
        end else if (int'(e) > MAX_E) begin
            return shamt_t'(MAX_E);
        end else begin
            return e;
        end
    endfunction

endpackage

// File: rtl/requant_param_chan.sv
// One replay channel: walks columns/rows of a job and streams table entries.
// Latency: first beat valid the cycle after i_start; one beat per accepted handshake.
// Backpressure: output register holds data/last stable while tvalid & ~tready.
module requant_param_chan #(
    parameter int DW    = 8,
    parameter int ROW_W = 16,
    parameter int COL_W = 7,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [ROW_W-1:0] i_num_rows,
    input  logic [COL_W-1:0] i_num_cols,
    input  logic [DW-1:0]    i_rd_data,
    output logic [AW-1:0]    o_rd_addr,
    output logic [DW-1:0]    o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_busy
);
    import requant_pkg::*;

    chan_state_t      r_state;
    chan_state_t      w_state_nxt;
    logic [ROW_W-1:0] r_nrows;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_next_row;
    logic [COL_W-1:0] r_ncols;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_next_col;
    logic             w_col_end;
    logic             w_final;
    logic             w_load;
    logic [DW-1:0]    r_tdata;
    logic             r_tlast;
    logic             r_tvalid;

    // r_col/r_row describe the beat currently sitting in the output register
    assign w_col_end  = (r_col == r_ncols - COL_W'(1));
    assign w_next_col = w_col_end ? '0 : r_col + COL_W'(1);
    assign w_next_row = w_col_end ? r_row + ROW_W'(1) : r_row;
    assign w_final    = r_tvalid & i_tready & w_col_end & (r_row == r_nrows - ROW_W'(1));
    assign w_load     = i_tready | ~r_tvalid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave IDLE on start, return once the final beat is taken
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CH_IDLE: if (i_start) w_state_nxt = CH_RUN;
            CH_RUN:  if (w_final) w_state_nxt = CH_IDLE;
            default: w_state_nxt = CH_IDLE;
        endcase
    end

    // Outputs: busy flag and table read address for the beat to load next
    always_comb begin
        o_busy    = (r_state == CH_RUN);
        o_rd_addr = '0;
        if (r_state == CH_RUN) begin
            o_rd_addr = w_next_col[AW-1:0];
        end
    end

    // Job counters and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nrows  <= '0;
            r_ncols  <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (r_state == CH_IDLE) begin
            if (i_start) begin
                r_nrows  <= i_num_rows;
                r_ncols  <= i_num_cols;
                r_row    <= '0;
                r_col    <= '0;
                r_tdata  <= i_rd_data;
                r_tlast  <= (i_num_cols == COL_W'(1));
                r_tvalid <= 1'b1;
            end
        end else if (w_load) begin
            if (w_final) begin
                r_row    <= '0;
                r_col    <= '0;
                r_tlast  <= 1'b0;
                r_tvalid <= 1'b0;
            end else begin
                r_row    <= w_next_row;
                r_col    <= w_next_col;
                r_tdata  <= i_rd_data;
                r_tlast  <= (w_next_col == r_ncols - COL_W'(1));
                r_tvalid <= 1'b1;
            end
        end
    end

    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;
    assign o_tvalid = r_tvalid;

endmodule

// File: rtl/requant_param_streamer.sv
// Bias/m/e table holder replaying each table once per row on three independent streams.
// Latency: first beats one cycle after start; done one cycle after the last channel ends.
// Backpressure: each stream stalls on its own tready; skew between streams is legal.
// Optional: define REQP_E_CLAMP_EN to saturate written e entries into [0, MAX_E].
module requant_param_streamer #(
    parameter int D_W     = requant_pkg::D_W,
    parameter int D_W_ACC = requant_pkg::D_W_ACC,
    parameter int N_COLS  = 64,
    parameter int ROW_W   = 16,
    parameter int COL_W   = $clog2(N_COLS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [COL_W-1:0]   cfg_addr,
    input  logic [D_W_ACC-1:0] cfg_bias,
    input  logic [D_W_ACC-1:0] cfg_m,
    input  logic [D_W-1:0]     cfg_e,
    input  logic               start,
    input  logic [ROW_W-1:0]   num_rows,
    input  logic [COL_W-1:0]   num_cols,
    output logic               busy,
    output logic               done,
    output logic [D_W_ACC-1:0] bias_tdata,
    output logic               bias_tlast,
    output logic               bias_tvalid,
    input  logic               bias_tready,
    output logic [D_W_ACC-1:0] m_tdata,
    output logic               m_tlast,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [D_W-1:0]     e_tdata,
    output logic               e_tlast,
    output logic               e_tvalid,
    input  logic               e_tready
);
    import requant_pkg::*;

    localparam int AW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

    logic [D_W_ACC-1:0] r_bias_tab [N_COLS];
    logic [D_W_ACC-1:0] r_m_tab    [N_COLS];
    logic [D_W-1:0]     r_e_tab    [N_COLS];

    logic               w_start_ok;
    logic               w_empty_job;
    logic               w_chan_start;
    logic [COL_W-1:0]   w_cols;
    logic [D_W-1:0]     w_e_wr;
    logic               w_bias_busy;
    logic               w_m_busy;
    logic               w_e_busy;
    logic               w_busy;
    logic               r_busy_q;
    logic               r_empty_done;
    logic [AW-1:0]      w_bias_addr;
    logic [AW-1:0]      w_m_addr;
    logic [AW-1:0]      w_e_addr;

    assign w_busy       = w_bias_busy | w_m_busy | w_e_busy;
    assign w_start_ok   = start & ~w_busy;
    assign w_cols       = (num_cols > COL_W'(N_COLS)) ? COL_W'(N_COLS) : num_cols;
    assign w_empty_job  = (num_rows == '0) || (w_cols == '0);
    assign w_chan_start = w_start_ok & ~w_empty_job;

`ifdef REQP_E_CLAMP_EN
    assign w_e_wr = D_W'(clamp_e(shamt_t'(cfg_e)));
`else
    assign w_e_wr = cfg_e;
`endif

    // Table writes: only while idle and in range; contents survive reset
    always_ff @(posedge clk) begin
        if (cfg_we && !w_busy && (cfg_addr < COL_W'(N_COLS))) begin
            r_bias_tab[cfg_addr[AW-1:0]] <= cfg_bias;
            r_m_tab[cfg_addr[AW-1:0]]    <= cfg_m;
            r_e_tab[cfg_addr[AW-1:0]]    <= w_e_wr;
        end
    end

    // Job-end tracking: falling busy, or an empty job that never goes busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_q     <= 1'b0;
            r_empty_done <= 1'b0;
        end else begin
            r_busy_q     <= w_busy;
            r_empty_done <= w_start_ok & w_empty_job;
        end
    end

    assign busy = w_busy;
    assign done = r_empty_done | (r_busy_q & ~w_busy);

    requant_param_chan #(.DW(D_W_ACC), .ROW_W(ROW_W), .COL_W(COL_W), .AW(AW)) u_bias_chan (
        .clk(clk), .rst_n(rst_n), .i_start(w_chan_start),
        .i_num_rows(num_rows), .i_num_cols(w_cols),
        .i_rd_data(r_bias_tab[w_bias_addr]), .o_rd_addr(w_bias_addr),
        .o_tdata(bias_tdata), .o_tlast(bias_tlast), .o_tvalid(bias_tvalid),
        .i_tready(bias_tready), .o_busy(w_bias_busy)
    );

    requant_param_chan #(.DW(D_W_ACC), .ROW_W(ROW_W), .COL_W(COL_W), .AW(AW)) u_m_chan (
        .clk(clk), .rst_n(rst_n), .i_start(w_chan_start),
        .i_num_rows(num_rows), .i_num_cols(w_cols),
        .i_rd_data(r_m_tab[w_m_addr]), .o_rd_addr(w_m_addr),
        .o_tdata(m_tdata), .o_tlast(m_tlast), .o_tvalid(m_tvalid),
        .i_tready(m_tready), .o_busy(w_m_busy)
    );

    requant_param_chan #(.DW(D_W), .ROW_W(ROW_W), .COL_W(COL_W), .AW(AW)) u_e_chan (
        .clk(clk), .rst_n(rst_n), .i_start(w_chan_start),
        .i_num_rows(num_rows), .i_num_cols(w_cols),
        .i_rd_data(r_e_tab[w_e_addr]), .o_rd_addr(w_e_addr),
        .o_tdata(e_tdata), .o_tlast(e_tlast), .o_tvalid(e_tvalid),
        .i_tready(e_tready), .o_busy(w_e_busy)
    );

endmodule
